// File: rtl/window_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_scan_ctrl                                                           |
// | Sequences band loads and window steps of the sliding-window shift stage    |
// | and hands each window to the convolution engine over valid/ready.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module window_scan_ctrl #(
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5,
  parameter int FILTER_SIZE  = 3,
  parameter int CW           = $clog2(IMAGE_WIDTH),
  parameter int RW           = $clog2(IMAGE_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          buf_req,
  input  logic          buf_valid,
  output logic          shift_en,
  output logic          shift_buffer,
  input  logic          window_valid,
  input  logic          new_buffer,
  output logic          conv_valid,
  input  logic          conv_ready,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          busy,
  output logic          frame_done,
  output logic          seq_err
);

  localparam logic [CW-1:0] c_LAST_COL = CW'(IMAGE_WIDTH - FILTER_SIZE);
  localparam logic [RW-1:0] c_LAST_ROW = RW'(IMAGE_HEIGHT - FILTER_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_ISSUE = 3'd4,
    S_SHIFT = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_settled;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_seq_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_REQ;
      S_REQ:   if (buf_valid) w_next = S_LOAD;
      S_LOAD:  w_next = S_WAIT;
      // The first WAIT cycle lets the shift stage output settle.
      S_WAIT:  if (r_settled && window_valid) w_next = S_ISSUE;
      S_ISSUE: if (conv_ready) w_next = (r_col == c_LAST_COL) ? S_NEXT : S_SHIFT;
      S_SHIFT: w_next = S_WAIT;
      S_NEXT:  w_next = (r_row == c_LAST_ROW) ? S_DONE : S_REQ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settled <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_settled <= (r_state == S_WAIT) && !abort;
      // Abort freezes the window position and the error flag.
      if (!abort) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_col     <= '0;
              r_row     <= '0;
              r_seq_err <= 1'b0;
            end
          end
          S_WAIT: begin
            if (new_buffer && (r_col < c_LAST_COL)) r_seq_err <= 1'b1;
          end
          S_SHIFT: r_col <= r_col + CW'(1);
          S_NEXT: begin
            if (r_row != c_LAST_ROW) begin
              r_row <= r_row + RW'(1);
              r_col <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign buf_req      = (r_state == S_REQ);
  assign shift_en     = (r_state == S_LOAD);
  assign shift_buffer = (r_state == S_SHIFT);
  assign conv_valid   = (r_state == S_ISSUE);
  assign frame_done   = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE);
  assign win_col      = r_col;
  assign win_row      = r_row;
  assign seq_err      = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_window_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_window_scan_ctrl                                                        |
// | Randomized scenario bench with a shift-stage model and raster-order model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_window_scan_ctrl;

  localparam int W    = 5;
  localparam int H    = 5;
  localparam int F    = 3;
  localparam int CW   = $clog2(W);
  localparam int RW   = $clog2(H);
  localparam int LC   = W - F;
  localparam int LR   = H - F;
  localparam int NWIN = (LC + 1) * (LR + 1);

  logic          clk, rst, start, abort, buf_valid, window_valid, new_buffer, conv_ready;
  logic          buf_req, shift_en, shift_buffer, conv_valid, busy, frame_done, seq_err;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;

  int n_checks = 0;
  int n_fail   = 0;

  // Event log filled by the monitor; tasks compare deltas against the model.
  int cyc = 0;
  int xr[$], xc[$], xcyc[$], start_q[$], req_q[$], se_q[$], cvr_q[$], seqd_q[$];
  int n_sb = 0, excl_bad = 0, stall_follow = 0, stall_bad = 0;
  int req_hi_r2 = 0, se_gap_bad = 0, last_accept = -10;
  bit prev_req = 0, prev_cv = 0, prev_stall = 0;
  int pr = 0, pc = 0, wv_cnt = -1, wv_lat_max = 0;

  window_scan_ctrl #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .FILTER_SIZE (F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .buf_req     (buf_req),
    .buf_valid   (buf_valid),
    .shift_en    (shift_en),
    .shift_buffer(shift_buffer),
    .window_valid(window_valid),
    .new_buffer  (new_buffer),
    .conv_valid  (conv_valid),
    .conv_ready  (conv_ready),
    .win_col     (win_col),
    .win_row     (win_row),
    .busy        (busy),
    .frame_done  (frame_done),
    .seq_err     (seq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor plus shift-stage model: window appears wv_lat cycles after the
  // cycle following each load/advance strobe, and is dropped on a band request.
  initial begin
    window_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (conv_valid && conv_ready) begin
        xr.push_back(int'(win_row));
        xc.push_back(int'(win_col));
        xcyc.push_back(cyc);
      end
      if (start && !busy) start_q.push_back(cyc);
      if (buf_req && !prev_req) req_q.push_back(cyc);
      if (shift_en) begin
        se_q.push_back(cyc);
        if (last_accept != cyc - 1) se_gap_bad++;
      end
      if (buf_req && buf_valid) last_accept = cyc;
      if (shift_buffer) n_sb++;
      if (conv_valid && !prev_cv) cvr_q.push_back(cyc);
      if (frame_done) seqd_q.push_back(int'(seq_err));
      if (shift_en && shift_buffer) excl_bad++;
      if (prev_stall) begin
        stall_follow++;
        if (!conv_valid || int'(win_row) != pr || int'(win_col) != pc || shift_buffer) stall_bad++;
      end
      if (buf_req && int'(win_row) == 2) req_hi_r2++;
      prev_req   = buf_req;
      prev_cv    = conv_valid;
      prev_stall = conv_valid && !conv_ready && !abort && !rst;
      pr         = int'(win_row);
      pc         = int'(win_col);
      if (buf_req) begin
        window_valid = 1'b0;
        wv_cnt       = -1;
      end else if (shift_en || shift_buffer) begin
        window_valid = 1'b0;
        wv_cnt       = int'($urandom_range(wv_lat_max, 0));
      end else if (wv_cnt == 0) begin
        window_valid = 1'b1;
      end else if (wv_cnt > 0) begin
        wv_cnt--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 plain, 1 stall (1,1), 2 late band 2, 3 new_buffer in WAIT at col arg,
  // 4 start mid-frame, 5 abort at ISSUE (1,0)
  task automatic run_frame(input int mode, input int rdy_pct, input int bv_pct,
                           input int arg, output bit ok);
    int stall = 0;
    int dly   = 0;
    bit done  = 0;
    ok         = 0;
    conv_ready = 1'b1;
    buf_valid  = 1'b1;
    start      = 1'b1;
    tick();
    for (int i = 0; i < 3000; i++) begin
      start      = 1'b0;
      abort      = 1'b0;
      new_buffer = 1'b0;
      conv_ready = int'($urandom_range(99, 0)) < rdy_pct;
      buf_valid  = int'($urandom_range(99, 0)) < bv_pct;
      case (mode)
        1: if (conv_valid && int'(win_row) == 1 && int'(win_col) == 1 && stall < 7) begin
             conv_ready = 1'b0;
             stall++;
           end
        2: if (buf_req && int'(win_row) == 2 && dly < 10) begin
             buf_valid = 1'b0;
             dly++;
           end
        3: if (!done && busy && int'(win_row) == 0 && int'(win_col) == arg && !buf_req &&
               !shift_en && !shift_buffer && !conv_valid && !frame_done) begin
             new_buffer = 1'b1;
             done       = 1;
           end
        4: if (!done && conv_valid && int'(win_row) == 1 && int'(win_col) == 1) begin
             start = 1'b1;
             done  = 1;
           end
        5: if (conv_valid && int'(win_row) == 1 && int'(win_col) == 0) begin
             abort      = 1'b1;
             conv_ready = 1'b0;
             ok         = 1;
             tick();
             abort = 1'b0;
             return;
           end
        default: ;
      endcase
      if (frame_done) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    start      = 1'b0;
    new_buffer = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; buf_valid = 1'b0;
    conv_ready = 1'b0; new_buffer = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({buf_req, shift_en, shift_buffer, conv_valid, busy, frame_done, seq_err} !== 7'b0 ||
        win_col !== '0 || win_row !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got strobes=%b col=%0d row=%0d, expected all 0",
               {buf_req, shift_en, shift_buffer, conv_valid, busy, frame_done, seq_err},
               win_col, win_row);
    end
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || buf_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_without_start: got busy=%b buf_req=%b, expected 0 0", busy, buf_req);
    end
  endtask

  task automatic test_nominal();
    int x0, s0, r0, e0, c0, d0, sb0, ex0, ks;
    bit ok;
    x0 = xr.size(); s0 = start_q.size(); r0 = req_q.size(); e0 = se_q.size();
    c0 = cvr_q.size(); d0 = seqd_q.size(); sb0 = n_sb; ex0 = excl_bad;
    wv_lat_max = 0;
    run_frame(0, 100, 100, 0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL nominal_timeout: got no frame_done, expected one"); end
    n_checks++;
    if (xr.size() - x0 != NWIN) begin
      n_fail++; $display("FAIL nominal_xfers: got %0d, expected %0d", xr.size() - x0, NWIN);
    end
    for (int i = 0; i < NWIN && x0 + i < xr.size(); i++) begin
      n_checks++;
      if (xr[x0+i] != i / (LC + 1) || xc[x0+i] != i % (LC + 1)) begin
        n_fail++;
        $display("FAIL nominal_order: window %0d got (%0d,%0d), expected (%0d,%0d)",
                 i, xr[x0+i], xc[x0+i], i / (LC + 1), i % (LC + 1));
      end
    end
    n_checks++;
    if (req_q.size() - r0 != LR + 1 || se_q.size() - e0 != LR + 1) begin
      n_fail++;
      $display("FAIL nominal_bands: got buf_req=%0d shift_en=%0d, expected %0d each",
               req_q.size() - r0, se_q.size() - e0, LR + 1);
    end
    n_checks++;
    if (n_sb - sb0 != LC * (LR + 1)) begin
      n_fail++; $display("FAIL nominal_shift_buffer: got %0d, expected %0d", n_sb - sb0, LC * (LR + 1));
    end
    n_checks++;
    if (seqd_q.size() - d0 != 1 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_done: got frame_done=%0d seq_err=%b, expected 1 0", seqd_q.size() - d0, seq_err);
    end
    n_checks++;
    if (excl_bad != ex0) begin
      n_fail++; $display("FAIL nominal_exclusive: got %0d overlaps, expected 0", excl_bad - ex0);
    end
    if (start_q.size() > s0 && req_q.size() > r0 && se_q.size() > e0 && cvr_q.size() > c0) begin
      ks = start_q[s0];
      n_checks++;
      if (req_q[r0] - ks != 1 || se_q[e0] - ks != 2 || cvr_q[c0] - ks != 5) begin
        n_fail++;
        $display("FAIL nominal_latency: got req=+%0d load=+%0d valid=+%0d, expected +1 +2 +5",
                 req_q[r0] - ks, se_q[e0] - ks, cvr_q[c0] - ks);
      end
    end else begin
      n_checks++; n_fail++;
      $display("FAIL nominal_latency: got missing events, expected start/req/load/valid");
    end
    for (int i = 0; i + 1 < NWIN && x0 + i + 1 < xr.size(); i++) begin
      if (i % (LC + 1) != LC) begin
        n_checks++;
        if (xcyc[x0+i+1] - xcyc[x0+i] != 4) begin
          n_fail++;
          $display("FAIL nominal_spacing: window %0d got %0d cycles, expected 4", i, xcyc[x0+i+1] - xcyc[x0+i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int x0, sf0, sb0, nsb0;
    bit ok;
    x0 = xr.size(); sf0 = stall_follow; sb0 = stall_bad; nsb0 = n_sb;
    wv_lat_max = 1;
    run_frame(1, 100, 100, 0, ok);
    n_checks++;
    if (!ok || xr.size() - x0 != NWIN) begin
      n_fail++; $display("FAIL stall_xfers: got %0d (done=%0d), expected %0d", xr.size() - x0, ok, NWIN);
    end
    for (int i = 0; i < NWIN && x0 + i < xr.size(); i++) begin
      n_checks++;
      if (xr[x0+i] != i / (LC + 1) || xc[x0+i] != i % (LC + 1)) begin
        n_fail++;
        $display("FAIL stall_order: window %0d got (%0d,%0d), expected (%0d,%0d)",
                 i, xr[x0+i], xc[x0+i], i / (LC + 1), i % (LC + 1));
      end
    end
    n_checks++;
    if (stall_follow - sf0 != 7 || stall_bad != sb0) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d held cycles with %0d bad, expected 7 with 0",
               stall_follow - sf0, stall_bad - sb0);
    end
    n_checks++;
    if (n_sb - nsb0 != LC * (LR + 1)) begin
      n_fail++; $display("FAIL stall_shift_buffer: got %0d, expected %0d", n_sb - nsb0, LC * (LR + 1));
    end
  endtask

  task automatic test_source_delay();
    int x0, rh0, g0, e0;
    bit ok;
    x0 = xr.size(); rh0 = req_hi_r2; g0 = se_gap_bad; e0 = se_q.size();
    wv_lat_max = 0;
    run_frame(2, 100, 100, 0, ok);
    n_checks++;
    if (!ok || xr.size() - x0 != NWIN) begin
      n_fail++; $display("FAIL srcdly_xfers: got %0d (done=%0d), expected %0d", xr.size() - x0, ok, NWIN);
    end
    n_checks++;
    if (req_hi_r2 - rh0 != 11) begin
      n_fail++; $display("FAIL srcdly_req_hold: got %0d buf_req cycles, expected 11", req_hi_r2 - rh0);
    end
    n_checks++;
    if (se_gap_bad != g0 || se_q.size() - e0 != LR + 1) begin
      n_fail++;
      $display("FAIL srcdly_load: got %0d misplaced of %0d loads, expected 0 of %0d",
               se_gap_bad - g0, se_q.size() - e0, LR + 1);
    end
  endtask

  task automatic test_seq_error();
    int d0;
    bit ok;
    wv_lat_max = 0;
    d0 = seqd_q.size();
    run_frame(3, 100, 100, 1, ok);
    n_checks++;
    if (!ok || seqd_q.size() - d0 != 1) begin
      n_fail++; $display("FAIL seqerr_frame: got done=%0d, expected 1", seqd_q.size() - d0);
    end else if (seqd_q[d0] != 1) begin
      n_fail++; $display("FAIL seqerr_at_done: got %0d, expected 1", seqd_q[d0]);
    end
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++; $display("FAIL seqerr_sticky: got %b, expected 1", seq_err);
    end
    // Restart clears it; new_buffer at the last column is legal.
    d0 = seqd_q.size();
    run_frame(3, 100, 100, LC, ok);
    n_checks++;
    if (!ok || seqd_q.size() - d0 != 1) begin
      n_fail++; $display("FAIL seqerr_clear_frame: got done=%0d, expected 1", seqd_q.size() - d0);
    end else if (seqd_q[d0] != 0) begin
      n_fail++; $display("FAIL seqerr_clear: got %0d at frame_done, expected 0", seqd_q[d0]);
    end
  endtask

  task automatic test_abort();
    int x0;
    bit ok;
    x0 = xr.size();
    run_frame(5, 100, 100, 0, ok);
    n_checks++;
    if ({buf_req, shift_en, shift_buffer, conv_valid, frame_done, busy} !== 6'b0 ||
        win_row !== RW'(1) || win_col !== CW'(0)) begin
      n_fail++;
      $display("FAIL abort_idle: got strobes=%b row=%0d col=%0d, expected 000000 1 0",
               {buf_req, shift_en, shift_buffer, conv_valid, frame_done, busy}, win_row, win_col);
    end
    n_checks++;
    if (xr.size() - x0 != LC + 1) begin
      n_fail++; $display("FAIL abort_xfers: got %0d, expected %0d", xr.size() - x0, LC + 1);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_stays_idle: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_rst_mid_frame();
    int x0;
    bit ok, seen;
    seen = 0;
    conv_ready = 1'b1; buf_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (shift_buffer) begin seen = 1; break; end
      tick();
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_reach_shift: got no shift_buffer, expected one"); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({buf_req, shift_en, shift_buffer, conv_valid, busy, frame_done, seq_err} !== 7'b0 ||
        win_col !== '0 || win_row !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got strobes=%b col=%0d row=%0d, expected all 0",
               {buf_req, shift_en, shift_buffer, conv_valid, busy, frame_done, seq_err}, win_col, win_row);
    end
    tick();
    rst = 1'b0;
    tick();
    x0 = xr.size();
    run_frame(0, 100, 100, 0, ok);
    n_checks++;
    if (!ok || xr.size() - x0 != NWIN || xr[x0] != 0 || xc[x0] != 0) begin
      n_fail++; $display("FAIL rst_full_frame: got %0d windows (done=%0d), expected %0d from (0,0)",
                         xr.size() - x0, ok, NWIN);
    end
  endtask

  task automatic test_ignored_start();
    int x0, d0;
    bit ok;
    x0 = xr.size(); d0 = seqd_q.size();
    run_frame(4, 100, 100, 0, ok);
    n_checks++;
    if (!ok || xr.size() - x0 != NWIN || seqd_q.size() - d0 != 1) begin
      n_fail++; $display("FAIL ignstart_xfers: got %0d windows, %0d done, expected %0d, 1",
                         xr.size() - x0, seqd_q.size() - d0, NWIN);
    end
    for (int i = 0; i < NWIN && x0 + i < xr.size(); i++) begin
      n_checks++;
      if (xr[x0+i] != i / (LC + 1) || xc[x0+i] != i % (LC + 1)) begin
        n_fail++;
        $display("FAIL ignstart_order: window %0d got (%0d,%0d), expected (%0d,%0d)",
                 i, xr[x0+i], xc[x0+i], i / (LC + 1), i % (LC + 1));
      end
    end
  endtask

  task automatic test_random();
    int x0, e0, sb0, ex0, st0, d0, bad;
    bit ok;
    for (int f = 0; f < 6; f++) begin
      x0 = xr.size(); e0 = se_q.size(); sb0 = n_sb; ex0 = excl_bad; st0 = stall_bad; d0 = seqd_q.size();
      wv_lat_max = int'($urandom_range(3, 0));
      run_frame(0, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0, ok);
      n_checks++;
      if (!ok || xr.size() - x0 != NWIN) begin
        n_fail++; $display("FAIL rand_xfers: frame %0d got %0d, expected %0d", f, xr.size() - x0, NWIN);
      end
      bad = 0;
      for (int i = 0; i < NWIN && x0 + i < xr.size(); i++)
        if (xr[x0+i] != i / (LC + 1) || xc[x0+i] != i % (LC + 1)) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL rand_order: frame %0d got %0d out-of-order windows, expected 0", f, bad);
      end
      n_checks++;
      if (se_q.size() - e0 != LR + 1 || n_sb - sb0 != LC * (LR + 1)) begin
        n_fail++; $display("FAIL rand_strobes: frame %0d got load=%0d step=%0d, expected %0d %0d",
                           f, se_q.size() - e0, n_sb - sb0, LR + 1, LC * (LR + 1));
      end
      n_checks++;
      if (excl_bad != ex0 || stall_bad != st0 || seqd_q.size() - d0 != 1 || seq_err !== 1'b0) begin
        n_fail++; $display("FAIL rand_protocol: frame %0d got overlap=%0d stallbad=%0d done=%0d err=%b, expected 0 0 1 0",
                           f, excl_bad - ex0, stall_bad - st0, seqd_q.size() - d0, seq_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_source_delay();
    test_seq_error();
    test_abort();
    test_rst_mid_frame();
    test_ignored_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
